ram_arbiter: RTL
================

# ram_arbiter

Sequential arbiter that shares the single-ported unified RAM between the instruction-fetch port and the data port driven by the control unit's MemRead/MemWrite/datomic decode. It serialises accesses through a small FSM, applies fair priority when both ports request, and owns the LL/SC link register so that store-conditional success is decided here. It sits between the pipeline's fetch/memory stages and the RAM model.

## Interface
- ADDR_W, 32, byte address width
- DATA_W, 32, word width

- CLK  in  1  clock, rising edge
- nRST  in  1  asynchronous active-low reset
- iREN  in  1  instruction read request, held until iwait low
- iaddr  in  ADDR_W  instruction byte address
- iwait  out  1  1 = instruction request not complete
- iload  out  DATA_W  fetched word, valid when iREN & !iwait
- dREN  in  1  data read request (LW/LL), held until dwait low
- dWEN  in  1  data write request (SW/SC), held until dwait low
- datomic  in  1  qualifies dREN as LL, dWEN as SC
- daddr  in  ADDR_W  data byte address
- dstore  in  DATA_W  write data
- dwait  out  1  1 = data request not complete
- dload  out  DATA_W  read word; for SC: 1 = success, 0 = fail
- ramREN  out  1  RAM read strobe
- ramWEN  out  1  RAM write strobe
- ramaddr  out  ADDR_W  word-aligned address {addr[ADDR_W-1:2],2'b00}
- ramstore  out  DATA_W  RAM write data
- ramload  in  DATA_W  RAM read data
- ram_ready  in  1  RAM completes current access this cycle

## Operation
- States: IDLE, IACC, DACC, SCFAIL.
- IDLE: no RAM strobes. Evaluate requests (dREN|dWEN is a data request; dREN&dWEN together is illegal, treat as write):
  - data only -> DACC, or SCFAIL if SC with failing link check.
  - instruction only -> IACC.
  - both -> data wins unless last_grant==DATA, then IACC. last_grant updates on every grant.
- IACC: ramREN=1, ramaddr from iaddr. On ram_ready: iwait=0, iload=ramload, -> IDLE.
- DACC: ramREN=dREN, ramWEN=dWEN, ramaddr from daddr, ramstore=dstore. On ram_ready: dwait=0, dload=ramload (read) or 32'd1 (SC), -> IDLE.
- SCFAIL: no RAM strobes; dwait=0, dload=0, -> IDLE.
- Link register (link_addr word address, link_valid):
  - LL grant: link_addr<=daddr[ADDR_W-1:2], link_valid<=1 (at completion).
  - SC check in IDLE: success iff link_valid && link_addr==daddr[ADDR_W-1:2].
  - Any completed write (SW or successful SC) to link_addr clears link_valid; SC completion (either outcome) clears link_valid.
- iwait=1 whenever iREN and not completing this cycle; dwait likewise. Both 0 when no request.
- Requester-side changes while waiting are undefined; arbiter latches nothing but link state and grant.

## Timing
- Reset (nRST low, async): state=IDLE, last_grant=INSTR, link_valid=0, link_addr=0; all outputs 0 except iwait=iREN, dwait=dREN|dWEN; iload=dload=0.
- Minimum latency: request seen in IDLE cycle 0, access cycle 1; with ram_ready in cycle 1, wait drops in cycle 1 (combinational from ram_ready). Back-to-back accesses separated by one IDLE cycle.
- SC fail: request cycle 0, SCFAIL cycle 1, dwait low cycle 1, no RAM traffic.
- ram_ready ignored in IDLE/SCFAIL.
- Both ports never complete in the same cycle; at most one RAM strobe high.
- Reset mid-access aborts it: strobes drop immediately, no completion reported, link cleared.
- Starvation bound: with both ports continuously requesting, grants strictly alternate.

## Test plan
- Single fetch: iREN=1, iaddr=0x0000_0044, ram_ready one cycle after grant, ramload=0x2002_0005 -> ramREN=1, ramaddr=0x44, iwait low in cycle 2, iload=0x2002_0005.
- Contention: iREN and dREN held high from reset for 6 accesses -> grant order D,I,D,I,D,I; never both strobes.
- LL/SC success: LL 0x100 then SC 0x102 dstore=0xABCD -> SC does ramWEN at 0x100, dload=1, link_valid=0 after.
- LL/SC fail: LL 0x100, SW 0x100, SC 0x100 -> SC enters SCFAIL, no ramWEN, dload=0, dwait low one cycle after request.
- SC to different address: LL 0x100, SC 0x104 -> fail, dload=0; LL-less SC after reset -> fail.
- Reset mid-DACC: assert nRST low while ramWEN=1 -> ramWEN drops asynchronously, state IDLE, subsequent SC fails.

Source files
------------

// File: rtl/ram_arbiter.sv
// Arbiter that shares one single-ported RAM between instruction fetch and data access.
// It also holds the LL/SC link register, so store-conditional success is decided here.
module ram_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  output logic              iwait,
  output logic [DATA_W-1:0] iload,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic              datomic,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] dstore,
  output logic              dwait,
  output logic [DATA_W-1:0] dload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [DATA_W-1:0] ramstore,
  input  logic [DATA_W-1:0] ramload,
  input  logic              ram_ready
);

  typedef enum logic [1:0] {IDLE, IACC, DACC, SCFAIL} state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic              r_last_data;
  logic              r_link_valid;
  logic [ADDR_W-3:0] r_link_addr;

  logic              w_dreq;
  logic              w_sc;
  logic              w_ll;
  logic              w_sc_ok;
  logic [ADDR_W-3:0] w_dword;
  logic              w_unused;

  assign w_dreq   = dREN | dWEN;
  assign w_sc     = dWEN & datomic;
  assign w_ll     = dREN & ~dWEN & datomic;
  assign w_dword  = daddr[ADDR_W-1:2];
  assign w_sc_ok  = r_link_valid && (r_link_addr == w_dword);
  assign w_unused = ^{iaddr[1:0], daddr[1:0]};

  always_comb begin
    w_state_next = r_state;
    iwait        = iREN;
    dwait        = w_dreq;
    iload        = '0;
    dload        = '0;
    ramREN       = 1'b0;
    ramWEN       = 1'b0;
    ramaddr      = '0;
    ramstore     = '0;
    case (r_state)
      IDLE: begin
        // Data wins a tie unless it had the previous grant.
        if (w_dreq && (!iREN || !r_last_data))
          w_state_next = (w_sc && !w_sc_ok) ? SCFAIL : DACC;
        else if (iREN)
          w_state_next = IACC;
      end
      IACC: begin
        ramREN  = 1'b1;
        ramaddr = {iaddr[ADDR_W-1:2], 2'b00};
        if (ram_ready) begin
          iwait        = 1'b0;
          iload        = ramload;
          w_state_next = IDLE;
        end
      end
      DACC: begin
        ramREN   = dREN & ~dWEN;
        ramWEN   = dWEN;
        ramaddr  = {daddr[ADDR_W-1:2], 2'b00};
        ramstore = dstore;
        if (ram_ready) begin
          dwait        = 1'b0;
          dload        = w_sc ? {{(DATA_W-1){1'b0}}, 1'b1} : (dWEN ? '0 : ramload);
          w_state_next = IDLE;
        end
      end
      SCFAIL: begin
        dwait        = 1'b0;
        w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state      <= IDLE;
      r_last_data  <= 1'b0;
      r_link_valid <= 1'b0;
      r_link_addr  <= '0;
    end else begin
      r_state <= w_state_next;
      if (r_state == IDLE && w_state_next != IDLE)
        r_last_data <= (w_state_next != IACC);
      if (r_state == SCFAIL) begin
        r_link_valid <= 1'b0;
      end else if (r_state == DACC && ram_ready) begin
        // Any SC, or any store hitting the linked word, breaks the link.
        if (dWEN) begin
          if (datomic || r_link_addr == w_dword)
            r_link_valid <= 1'b0;
        end else if (w_ll) begin
          r_link_valid <= 1'b1;
          r_link_addr  <= w_dword;
        end
      end
    end
  end

endmodule
